fetch_hazard_sequencer: RTL and testbench

//  Sequences the fetch stage: drives PC_WRITE, PC_SOURCE and the IF/ID and ID/EX register controls.

---
 rtl/fetch_hazard_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_hazard_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_sequencer.sv
// rtl/fetch_hazard_sequencer.sv - fetch-stage sequencer: boot hold, load-use stall, EX redirect squash
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_hazard_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int SQUASH_LEN  = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        ex_jal_i,
  input  logic        ex_jalr_i,
  output logic        pc_write_o,
  output logic [1:0]  pc_source_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic [31:0] stall_count_o,
  output logic [31:0] squash_count_o
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int SW = (SQUASH_LEN  > 1) ? $clog2(SQUASH_LEN)  : 1;

  localparam logic [1:0] SRC_PC4    = 2'd0;
  localparam logic [1:0] SRC_JALR   = 2'd1;
  localparam logic [1:0] SRC_BRANCH = 2'd2;
  localparam logic [1:0] SRC_JAL    = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [SW-1:0]   squash_cnt_q, squash_cnt_d;

  logic            redirect;
  logic            load_use;
  logic [1:0]      redirect_src;

  // Hazard detection from the ID and EX stage fields.
  always_comb begin
    redirect = ex_jal_i | ex_jalr_i | ex_branch_taken_i;
    load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    // JAL beats JALR beats a taken branch when several fire together.
    if (ex_jal_i)       redirect_src = SRC_JAL;
    else if (ex_jalr_i) redirect_src = SRC_JALR;
    else                redirect_src = SRC_BRANCH;
  end

  // State, boot counter and squash counter registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= BW'(BOOT_CYCLES - 1);
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    squash_cnt_d  = squash_cnt_q;
    pc_write_o    = 1'b0;
    pc_source_o   = SRC_PC4;
    if_id_write_o = 1'b0;
    if_id_flush_o = 1'b1;
    id_ex_flush_o = 1'b1;
    case (state_q)
      ST_BOOT: begin
        // Fetch is frozen and both pipe registers are flushed while memory primes.
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (redirect) begin
          // Redirect wins over a coincident load-use: the stalled instruction is squashed anyway.
          pc_write_o    = 1'b1;
          pc_source_o   = redirect_src;
          if_id_write_o = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          state_d       = ST_SQUASH;
          squash_cnt_d  = SW'(SQUASH_LEN - 1);
        end else if (load_use) begin
          // Hold PC and IF/ID, inject one bubble into EX.
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          if_id_flush_o = 1'b0;
          id_ex_flush_o = 1'b1;
        end else begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
          if_id_flush_o = 1'b0;
          id_ex_flush_o = 1'b0;
        end
      end
      ST_SQUASH: begin
        // Wrong-path words still emerging from the fetch register are turned into NOPs.
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b0;
        if (squash_cnt_q == '0) state_d = ST_RUN;
        else                    squash_cnt_d = squash_cnt_q - 1'b1;
      end
      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = BW'(BOOT_CYCLES - 1);
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_count_q;
  logic [31:0] squash_count_q;

  // Count stall and redirect events seen only while running.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_count_q  <= '0;
      squash_count_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (redirect)      squash_count_q <= squash_count_q + 32'd1;
      else if (load_use) stall_count_q  <= stall_count_q + 32'd1;
    end
  end

  assign stall_count_o  = stall_count_q;
  assign squash_count_o = squash_count_q;
`else
  assign stall_count_o  = 32'd0;
  assign squash_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_hazard_sequencer.sv
// tb/tb_fetch_hazard_sequencer.sv - table-driven scoreboard bench for fetch_hazard_sequencer
module tb_fetch_hazard_sequencer;

  localparam int SQUASH_LEN = 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       jal;
    logic       jalr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;   // {pc_write, pc_source[1:0], if_id_write, if_id_flush, id_ex_flush}
    logic       sq;    // a squash window follows this vector
  } vec_t;

  localparam logic [5:0] E_BOOT  = 6'b0_00_0_1_1;
  localparam logic [5:0] E_IDLE  = 6'b1_00_1_0_0;
  localparam logic [5:0] E_STALL = 6'b0_00_0_0_1;
  localparam logic [5:0] E_SQ    = 6'b1_00_1_1_0;
  localparam logic [5:0] E_JALR  = 6'b1_01_1_1_1;
  localparam logic [5:0] E_BR    = 6'b1_10_1_1_1;
  localparam logic [5:0] E_JAL   = 6'b1_11_1_1_1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  in_t         cur = '0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [1:0]  pc_source;
  logic [31:0] stall_count, squash_count;

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] exp_q[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  fetch_hazard_sequencer #(.BOOT_CYCLES(2), .SQUASH_LEN(SQUASH_LEN)) dut (
    .clock_i(clk), .reset_i(rst),
    .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2),
    .id_uses_rs1_i(cur.u1), .id_uses_rs2_i(cur.u2),
    .ex_rd_i(cur.rd), .ex_mem_read_i(cur.mr),
    .ex_branch_taken_i(cur.br), .ex_jal_i(cur.jal), .ex_jalr_i(cur.jalr),
    .pc_write_o(pc_write), .pc_source_o(pc_source),
    .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .stall_count_o(stall_count), .squash_count_o(squash_count)
  );

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic mr,
                             input logic br, input logic jal, input logic jalr);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.jal = jal; v.jalr = jalr;
    return v;
  endfunction

  // Drive one cycle of stimulus after the edge, push its expectation, compare at the falling edge.
  task automatic step(input in_t v, input logic r, input logic [5:0] e, input int tag);
    logic [5:0] got;
    logic [5:0] want;
    @(posedge clk);
    #1;
    cur = v;
    rst = r;
    exp_q.push_back(e);
    @(negedge clk);
    got  = {pc_write, pc_source, if_id_write, if_id_flush, id_ex_flush};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL ctrl step %0d: got %b required %b", tag, got, want);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  in_t idle, noise;

  initial begin
    idle  = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    noise = mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);

    tbl[0]  = '{mk(5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0), E_IDLE,  1'b0};
    tbl[1]  = '{mk(5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0), E_STALL, 1'b0};
    tbl[2]  = '{mk(5'd1,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0), E_IDLE,  1'b0};
    tbl[3]  = '{mk(5'd7,  5'd2,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0), E_STALL, 1'b0};
    tbl[4]  = '{mk(5'd7,  5'd2,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0), E_IDLE,  1'b0};
    tbl[5]  = '{mk(5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0), E_IDLE,  1'b0};
    tbl[6]  = '{mk(5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0), E_BR,    1'b1};
    tbl[7]  = '{mk(5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 1'b1), E_JAL,   1'b1};
    tbl[8]  = '{mk(5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1), E_JALR,  1'b1};
    tbl[9]  = '{mk(5'd4,  5'd2,  1'b1, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0, 1'b1), E_JALR,  1'b1};
    tbl[10] = '{mk(5'd31, 5'd6,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0), E_STALL, 1'b0};

    // Reset then boot window: redirect and hazard inputs are ignored for exactly two cycles.
    step(noise, 1'b1, E_BOOT, 100);
    step(noise, 1'b0, E_BOOT, 101);
    step(noise, 1'b0, E_BOOT, 102);
    step(idle,  1'b0, E_IDLE, 103);
    chk32("stall_count after boot", stall_count, 32'd0);
    chk32("squash_count after boot", squash_count, 32'd0);

    // Table vectors in RUN; redirects are followed by a squash window fed with bubble noise.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].in, 1'b0, tbl[i].exp, i);
      if (tbl[i].sq) begin
        for (int k = 0; k < SQUASH_LEN; k++) step(noise, 1'b0, E_SQ, 200 + i);
        step(idle, 1'b0, E_IDLE, 300 + i);
      end
    end
    step(idle, 1'b0, E_IDLE, 400);

`ifdef FETCH_PERF_EN
    chk32("stall_count", stall_count, 32'd3);
    chk32("squash_count", squash_count, 32'd4);
    @(negedge clk);
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    step(tbl[1].in, 1'b0, E_STALL, 401);
    step(idle, 1'b0, E_IDLE, 402);
    chk32("stall_count wrap", stall_count, 32'd0);
`else
    chk32("stall_count tied", stall_count, 32'd0);
    chk32("squash_count tied", squash_count, 32'd0);
`endif

    // Reset arriving in the middle of a squash returns to the boot values next cycle.
    step(tbl[6].in, 1'b0, E_BR,   500);
    step(noise,     1'b1, E_SQ,   501);
    step(noise,     1'b0, E_BOOT, 502);
    step(noise,     1'b0, E_BOOT, 503);
    step(idle,      1'b0, E_IDLE, 504);
    chk32("stall_count after reset", stall_count, 32'd0);
    chk32("squash_count after reset", squash_count, 32'd0);

    // Back-to-back stalls each last one cycle and leave PC_SOURCE at PC+4.
    step(tbl[1].in, 1'b0, E_STALL, 600);
    step(idle,      1'b0, E_IDLE,  601);
    step(tbl[3].in, 1'b0, E_STALL, 602);
    step(idle,      1'b0, E_IDLE,  603);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
